// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl: turns debounced button levels into SHORT/LONG/REPEAT events behind a one-entry valid/ready register.
// Define BTN_AUTOREPEAT_EN to build the HELD state and REPEAT events; otherwise a long press waits for release.
module btn_event_ctrl #(
  parameter int N_BTN        = 4,
  parameter int IDW          = 2,
  parameter int TW           = 11,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic [N_BTN-1:0] btn,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDW-1:0]   evt_id,
  output logic [1:0]       evt_type,
  output logic             busy,
  output logic             overflow,
  input  logic             clr_overflow
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] PRESSED  = 2'd1;
  localparam logic [1:0] HELD     = 2'd2;
  localparam logic [1:0] WAIT_REL = 2'd3;
  localparam logic [1:0] SHORT    = 2'b01;
  localparam logic [1:0] LONG     = 2'b10;
  localparam logic [1:0] REPEAT   = 2'b11;
  if (LONG_TICKS < 1 || LONG_TICKS >= 2**TW || REPEAT_TICKS < 1 || REPEAT_TICKS >= 2**TW) begin : g_bad_ticks
    $error("btn_event_ctrl: tick counts must fit in TW bits and be nonzero");
  end
  logic [1:0]       state, state_nx;
  logic [TW-1:0]    timer, timer_nx, timer_inc;
  logic [N_BTN-1:0] btn_q, rise;
  logic [IDW-1:0]   cur_id, low_id;
  logic             cur_btn, emit, load;
  logic [1:0]       emit_type;
  assign rise      = btn & ~btn_q;
  assign cur_btn   = btn[cur_id];
  assign timer_inc = timer + 1'b1;
  assign load      = emit && (!evt_valid || evt_ready);
  assign busy      = state != IDLE;
  // Descending scan so the lowest rising index wins.
  always_comb begin
    low_id = '0;
    for (int i = N_BTN - 1; i >= 0; i--)
      if (rise[i]) low_id = IDW'(i);
  end
  always_comb begin
    state_nx  = state;
    timer_nx  = timer;
    emit      = 1'b0;
    emit_type = SHORT;
    case (state)
      IDLE: if (|rise) begin
        state_nx = PRESSED;
        timer_nx = '0;
      end
      PRESSED: if (!cur_btn) begin
        emit     = 1'b1;
        state_nx = IDLE;
      end else if (tick) begin
        timer_nx = timer_inc;
        if (timer_inc == TW'(LONG_TICKS)) begin
          emit      = 1'b1;
          emit_type = LONG;
          timer_nx  = '0;
`ifdef BTN_AUTOREPEAT_EN
          state_nx  = HELD;
`else
          state_nx  = WAIT_REL;
`endif
        end
      end
`ifdef BTN_AUTOREPEAT_EN
      HELD: if (!cur_btn) state_nx = IDLE;
      else if (tick) begin
        timer_nx = timer_inc;
        if (timer_inc == TW'(REPEAT_TICKS)) begin
          emit      = 1'b1;
          emit_type = REPEAT;
          timer_nx  = '0;
        end
      end
`endif
      default: if (!cur_btn) state_nx = IDLE;
    endcase
  end
  // btn_q resets to ones so a button held through reset needs a fresh press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      timer     <= '0;
      btn_q     <= '1;
      cur_id    <= '0;
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_type  <= 2'b00;
      overflow  <= 1'b0;
    end else begin
      btn_q <= btn;
      state <= state_nx;
      timer <= timer_nx;
      if (state == IDLE && |rise) cur_id <= low_id;
      if (load) begin
        evt_valid <= 1'b1;
        evt_id    <= cur_id;
        evt_type  <= emit_type;
      end else if (evt_ready) evt_valid <= 1'b0;
      if (emit && !load) overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_btn_event_ctrl.sv
// tb_btn_event_ctrl: directed scenarios plus randomized traffic checked against a press-duration event model.
module tb_btn_event_ctrl;
  localparam int L = 5;
  localparam int R = 2;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b0, tick = 1'b0, evt_ready = 1'b0, clr_overflow = 1'b0;
  logic [3:0] btn = 4'b0;
  logic evt_valid, busy, overflow;
  logic [1:0] evt_id, evt_type;
  int checks = 0, failures = 0;
  logic [3:0] m_q;
  bit m_trk, m_v, m_ovf;
  int m_cnt;
  logic [1:0] m_cid, m_id, m_ty;

  btn_event_ctrl #(.N_BTN(4), .IDW(2), .TW(11), .LONG_TICKS(L), .REPEAT_TICKS(R)) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .btn(btn), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_id(evt_id), .evt_type(evt_type), .busy(busy),
    .overflow(overflow), .clr_overflow(clr_overflow));

  always #5 clk = ~clk;

  task automatic m_reset();
    m_q = '1; m_trk = 0; m_cnt = 0; m_cid = 0; m_id = 0; m_ty = 0; m_v = 0; m_ovf = 0;
  endtask

  // Drive one cycle, advance the model by the same edge, return at the following negedge.
  task automatic cyc(input logic [3:0] b, input logic t, input logic r, input logic c);
    logic [3:0] rise;
    bit emit, drop;
    logic [1:0] ty;
    btn = b; tick = t; evt_ready = r; clr_overflow = c;
    @(posedge clk);
    rise = b & ~m_q; m_q = b; emit = 0; ty = 0;
    if (!m_trk) begin
      if (rise != 0) begin
        m_trk = 1; m_cnt = 0;
        for (int i = 0; i < 4; i++) if (rise[i]) begin m_cid = 2'(i); break; end
      end
    end else if (!b[m_cid]) begin
      if (m_cnt < L) begin emit = 1; ty = 2'b01; end
      m_trk = 0;
    end else if (t) begin
      m_cnt++;
      if (m_cnt == L) begin emit = 1; ty = 2'b10; end
      else if (AR && m_cnt > L && (m_cnt - L) % R == 0) begin emit = 1; ty = 2'b11; end
    end
    drop = emit && m_v && !r;
    if (emit && !drop) begin m_v = 1; m_id = m_cid; m_ty = ty; end
    else if (!emit && r) m_v = 0;
    if (drop) m_ovf = 1; else if (c) m_ovf = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    checks++; if ({evt_valid, busy, overflow} !== 3'b000) begin failures++; $display("FAIL reset_flags: got v/b/o=%b%b%b want 000", evt_valid, busy, overflow); end
    checks++; if ({evt_id, evt_type} !== 4'b0000) begin failures++; $display("FAIL reset_evt: got id=%0d type=%b want 0/00", evt_id, evt_type); end
    @(negedge clk); reset_n = 1'b1;
    cyc(4'b0, 0, 1, 0);
  endtask

  task automatic test_short();
    cyc(4'b0100, 0, 1, 0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL short_busy: got %b want 1", busy); end
    repeat (3) begin cyc(4'b0100, 1, 1, 0); cyc(4'b0100, 0, 1, 0); end
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL short_early: got valid %b want 0", evt_valid); end
    cyc(4'b0000, 0, 1, 0);
    checks++; if ({evt_valid, evt_id, evt_type, busy} !== {1'b1, 2'd2, 2'b01, 1'b0}) begin failures++; $display("FAIL short_evt: got v=%b id=%0d t=%b busy=%b want 1/2/01/0", evt_valid, evt_id, evt_type, busy); end
    cyc(4'b0000, 0, 1, 0);
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL short_drain: got valid %b want 0", evt_valid); end
  endtask

  task automatic test_long();
    int n;
    cyc(4'b0010, 0, 1, 0);
    repeat (4) cyc(4'b0010, 1, 1, 0);
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL long_early: got valid %b want 0", evt_valid); end
    cyc(4'b0010, 1, 1, 0);
    checks++; if ({evt_valid, evt_id, evt_type} !== {1'b1, 2'd1, 2'b10}) begin failures++; $display("FAIL long_evt: got v=%b id=%0d t=%b want 1/1/10", evt_valid, evt_id, evt_type); end
    n = 0;
    repeat (4) begin
      cyc(4'b0010, 1, 1, 0);
      if (evt_valid) begin
        n++;
        checks++; if (evt_type !== 2'b11) begin failures++; $display("FAIL repeat_type: got %b want 11", evt_type); end
      end
    end
    checks++; if (n !== (AR ? 2 : 0)) begin failures++; $display("FAIL repeat_count: got %0d want %0d", n, AR ? 2 : 0); end
    cyc(4'b0000, 0, 1, 0);
    checks++; if ({evt_valid, busy} !== 2'b00) begin failures++; $display("FAIL long_release: got v=%b busy=%b want 0/0", evt_valid, busy); end
  endtask

  task automatic test_simultaneous();
    cyc(4'b1010, 0, 1, 0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL simul_busy: got %b want 1", busy); end
    cyc(4'b1000, 0, 1, 0);
    checks++; if ({evt_valid, evt_id, evt_type} !== {1'b1, 2'd1, 2'b01}) begin failures++; $display("FAIL simul_evt: got v=%b id=%0d t=%b want 1/1/01", evt_valid, evt_id, evt_type); end
    repeat (3) cyc(4'b1000, 1, 1, 0);
    checks++; if ({evt_valid, busy} !== 2'b00) begin failures++; $display("FAIL simul_ignore3: got v=%b busy=%b want 0/0", evt_valid, busy); end
    cyc(4'b0000, 0, 1, 0);
    cyc(4'b1000, 0, 1, 0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL simul_repress: got busy %b want 1", busy); end
    cyc(4'b0000, 0, 1, 0);
    checks++; if ({evt_valid, evt_id, evt_type} !== {1'b1, 2'd3, 2'b01}) begin failures++; $display("FAIL simul_evt3: got v=%b id=%0d t=%b want 1/3/01", evt_valid, evt_id, evt_type); end
    cyc(4'b0000, 0, 1, 0);
  endtask

  task automatic test_overflow();
    cyc(4'b0001, 0, 0, 0); cyc(4'b0000, 0, 0, 0);
    cyc(4'b0100, 0, 0, 0); cyc(4'b0000, 0, 0, 0);
    checks++; if ({evt_valid, evt_id, evt_type, overflow} !== {1'b1, 2'd0, 2'b01, 1'b1}) begin failures++; $display("FAIL ovf_drop: got v=%b id=%0d t=%b ovf=%b want 1/0/01/1", evt_valid, evt_id, evt_type, overflow); end
    cyc(4'b0000, 0, 0, 1);
    checks++; if ({overflow, evt_valid, evt_id} !== {1'b0, 1'b1, 2'd0}) begin failures++; $display("FAIL ovf_clear: got ovf=%b v=%b id=%0d want 0/1/0", overflow, evt_valid, evt_id); end
    cyc(4'b0100, 0, 0, 0); cyc(4'b0000, 0, 0, 1);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set_wins: got %b want 1", overflow); end
    cyc(4'b0000, 0, 0, 1);
    cyc(4'b0000, 0, 1, 0);
    checks++; if ({evt_valid, overflow} !== 2'b00) begin failures++; $display("FAIL ovf_drain: got v=%b ovf=%b want 0/0", evt_valid, overflow); end
  endtask

  task automatic test_release_on_tick();
    cyc(4'b0010, 0, 1, 0);
    repeat (4) cyc(4'b0010, 1, 1, 0);
    cyc(4'b0000, 1, 1, 0);
    checks++; if ({evt_valid, evt_id, evt_type} !== {1'b1, 2'd1, 2'b01}) begin failures++; $display("FAIL rel_tick: got v=%b id=%0d t=%b want 1/1/01", evt_valid, evt_id, evt_type); end
    cyc(4'b0000, 0, 1, 0);
  endtask

  task automatic test_reset_held();
    reset_n = 1'b0; m_reset(); btn = 4'b0001;
    @(negedge clk); @(negedge clk); reset_n = 1'b1;
    repeat (3) cyc(4'b0001, 1, 1, 0);
    checks++; if ({evt_valid, busy} !== 2'b00) begin failures++; $display("FAIL held_reset: got v=%b busy=%b want 0/0", evt_valid, busy); end
    cyc(4'b0000, 0, 0, 0);
    cyc(4'b0001, 0, 0, 0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL held_repress: got busy %b want 1", busy); end
    cyc(4'b0000, 0, 0, 0);
    cyc(4'b0010, 0, 0, 0); cyc(4'b0000, 0, 0, 0);
    cyc(4'b0100, 0, 0, 0);
    checks++; if ({evt_valid, busy, overflow} !== 3'b111) begin failures++; $display("FAIL pre_abort: got v/b/o=%b%b%b want 111", evt_valid, busy, overflow); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({evt_valid, busy, overflow, evt_id, evt_type} !== 7'b0) begin failures++; $display("FAIL async_reset: got v=%b b=%b o=%b id=%0d t=%b want all 0", evt_valid, busy, overflow, evt_id, evt_type); end
    m_reset(); btn = 4'b0;
    @(negedge clk); reset_n = 1'b1;
    cyc(4'b0000, 0, 1, 0);
  endtask

  task automatic test_random();
    logic [3:0] b;
    b = 4'b0;
    repeat (3000) begin
      for (int i = 0; i < 4; i++) if ($urandom % 24 == 0) b[i] = ~b[i];
      cyc(b, ($urandom % 3) == 0, ($urandom % 4) != 0, ($urandom % 16) == 0);
      checks++;
      if ({evt_valid, busy, overflow} !== {m_v, m_trk, m_ovf} || (m_v && {evt_id, evt_type} !== {m_id, m_ty})) begin
        failures++;
        $display("FAIL random: got v=%b b=%b o=%b id=%0d t=%b want v=%b b=%b o=%b id=%0d t=%b", evt_valid, busy, overflow, evt_id, evt_type, m_v, m_trk, m_ovf, m_id, m_ty);
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_short();
    test_long();
    test_simultaneous();
    test_overflow();
    test_release_on_tick();
    test_reset_held();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/btn_event_ctrl.md
Name: btn_event_ctrl

Overview:
Converts the debounced button levels from the per-button debouncers into discrete, timestamp-free user events: short press, long press, and auto-repeat. Arbitrates between buttons so only one is tracked at a time, and delivers events through a single-entry valid/ready output register. Sits between the debouncer bank and the time-set FSM of the clock.

Parameters:
N_BTN, 4, number of debounced button inputs
IDW, 2, width of button index output (>= clog2(N_BTN))
TW, 11, timer width in ticks
LONG_TICKS, 1000, ticks held before a long-press event (1 <= LONG_TICKS < 2^TW)
REPEAT_TICKS, 200, ticks between repeat events while held (1 <= REPEAT_TICKS < 2^TW)

Ports:
clk  in  1  system clock (50 MHz)
reset_n  in  1  asynchronous, active-low reset
tick  in  1  one-cycle timebase strobe (nominally 1 ms)
btn  in  N_BTN  debounced button levels, 1 = pressed
evt_valid  out  1  event register holds an event
evt_ready  in  1  consumer accepts event this cycle
evt_id  out  IDW  index of button that produced event
evt_type  out  2  01 SHORT, 10 LONG, 11 REPEAT
busy  out  1  a button is being tracked (state != IDLE)
overflow  out  1  sticky: an event was dropped
clr_overflow  in  1  clears overflow

Behaviour:
- Reset (reset_n low, async): state IDLE, timer 0, evt_valid 0, evt_id 0, evt_type 00, busy 0, overflow 0, btn_q all ones (a button held through reset is ignored until released and pressed again).
- btn_q registers btn every cycle; rise = btn & ~btn_q.
- IDLE: if rise != 0, capture lowest set index as cur_id, timer <= 0, go PRESSED. Other rises that cycle are discarded.
- PRESSED: when btn[cur_id] == 0 -> emit SHORT, go IDLE. Else, on tick, timer++; when the increment makes timer == LONG_TICKS -> emit LONG, timer <= 0, go HELD (repeat enabled) or WAIT_REL.
- HELD: btn[cur_id] == 0 -> go IDLE, no event. Else, on tick, timer++; reaching REPEAT_TICKS -> emit REPEAT, timer <= 0.
- WAIT_REL: btn[cur_id] == 0 -> go IDLE, no event.
- If release and a terminal tick occur in the same cycle, release wins (PRESSED emits SHORT, HELD emits nothing).
- Outside IDLE, all buttons other than cur_id are ignored. Presses that began during tracking do not fire on return to IDLE (edge-only).
- Timer only advances on tick; a tick asserted continuously advances once per clk.
- Emit: if evt_valid == 0 or evt_ready == 1 this cycle, the event register loads {cur_id, type} and evt_valid = 1 next cycle (latency 1 clk from the detecting edge). Otherwise the event is dropped and overflow <= 1.
- evt_valid falls the cycle after evt_ready is high, unless a new event loads in the same cycle. evt_id/evt_type hold stable while evt_valid && !evt_ready.
- overflow: set has priority over clr_overflow in the same cycle.
- reset_n asserted mid-press aborts tracking with no event; a pending event is lost.

Optional Feature:
BTN_AUTOREPEAT_EN. If defined: after LONG, the FSM enters HELD and emits REPEAT every REPEAT_TICKS. If undefined: after LONG, the FSM enters WAIT_REL, HELD and the REPEAT logic are not built, and evt_type 11 never occurs.

Test Plan:
- LONG_TICKS=5: press btn[2] for 3 ticks, then release -> one event {id 2, SHORT}; busy 1 during the press, 0 the cycle after release.
- Hold btn[1] for 5 ticks -> {1, LONG} one clk after the 5th tick. With the macro and REPEAT_TICKS=2, hold 4 more ticks -> two {1, REPEAT}. Without the macro -> none.
- btn[3] and btn[1] rise in the same cycle -> only id 1 is tracked. Release btn[1] while btn[3] is still held -> no event for 3 until it is re-pressed.
- Hold evt_ready=0 and generate two SHORT events -> the first is held stable, the second is dropped, overflow=1. Pulse clr_overflow -> 0. Set and clear in the same cycle -> stays 1.
- Release on the same cycle as the 5th tick -> SHORT, not LONG.
- btn[0] held during reset_n low, then released and re-pressed after reset -> no event before the re-press. Assert reset_n mid-press -> all outputs 0 asynchronously.
